// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the fetch/decode/alu/tlblookup/wb processor.
// Generates the per-stage register enables and bubble/flush controls:
//   - a three-slot scoreboard (alu, tlb, wb) of in-flight register writes
//     stalls decode on read-after-write hazards (no bypass network);
//   - a taken branch in decode flushes the fetched instruction and masks
//     the following decode slot;
//   - a TLB miss freezes the pipe (only wb drains, with a bubble) until
//     the miss-done pulse.
// Saturating counters report stalled cycles and TLB miss entries.
// Ports:
//   clk_i, reset_i               clock, synchronous active-high reset
//   dec_*_i                      decode-stage instruction information
//   tlb_miss_i, tlb_miss_done_i  miss level / serviced pulse
//   enable_*_o                   per-stage pipeline register enables
//   bubble_alu_o, bubble_wb_o    force we=0 into the alu / wb stage register
//   flush_decode_o               clear the fetch->decode register
//   stall_cycles_o, miss_count_o performance counters
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned R0_ZERO = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              dec_valid_i,
  input  logic [REG_AW-1:0] dec_srca_addr_i,
  input  logic              dec_srca_used_i,
  input  logic [REG_AW-1:0] dec_srcb_addr_i,
  input  logic              dec_srcb_used_i,
  input  logic [REG_AW-1:0] dec_dest_addr_i,
  input  logic              dec_we_i,
  input  logic              dec_branch_taken_i,
  input  logic              tlb_miss_i,
  input  logic              tlb_miss_done_i,
  output logic              enable_pc_o,
  output logic              enable_decode_o,
  output logic              enable_alu_o,
  output logic              enable_tlblookup_o,
  output logic              enable_wb_o,
  output logic              bubble_alu_o,
  output logic              bubble_wb_o,
  output logic              flush_decode_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  miss_count_o
);

  typedef enum logic [0:0] {StRun, StMissWait} state_e;

  state_e            state_q, state_d;
  logic              kill_q, kill_d;
  logic              alu_v_q, alu_v_d, tlb_v_q, tlb_v_d, wb_v_q, wb_v_d;
  logic [REG_AW-1:0] alu_a_q, alu_a_d, tlb_a_q, tlb_a_d, wb_a_q, wb_a_d;
  logic [CNT_W-1:0]  stall_q, miss_q;
  logic              miss_inc;
  logic              dv, hit_a, hit_b, raw;

  function automatic logic slot_hit(input logic v, input logic [REG_AW-1:0] slot_a,
                                    input logic [REG_AW-1:0] src_a);
    return v && (slot_a == src_a) && !((R0_ZERO != 0) && (src_a == '0));
  endfunction

  always_comb begin
    // The instruction behind an accepted taken branch is wrong-path.
    dv    = dec_valid_i & ~kill_q;
    hit_a = slot_hit(alu_v_q, alu_a_q, dec_srca_addr_i) |
            slot_hit(tlb_v_q, tlb_a_q, dec_srca_addr_i) |
            slot_hit(wb_v_q, wb_a_q, dec_srca_addr_i);
    hit_b = slot_hit(alu_v_q, alu_a_q, dec_srcb_addr_i) |
            slot_hit(tlb_v_q, tlb_a_q, dec_srcb_addr_i) |
            slot_hit(wb_v_q, wb_a_q, dec_srcb_addr_i);
    raw   = dv & ((dec_srca_used_i & hit_a) | (dec_srcb_used_i & hit_b));
  end

  always_comb begin
    state_d            = state_q;
    kill_d             = 1'b0;
    alu_v_d            = alu_v_q;
    alu_a_d            = alu_a_q;
    tlb_v_d            = tlb_v_q;
    tlb_a_d            = tlb_a_q;
    wb_v_d             = wb_v_q;
    wb_a_d             = wb_a_q;
    miss_inc           = 1'b0;
    enable_pc_o        = 1'b1;
    enable_decode_o    = 1'b1;
    enable_alu_o       = 1'b1;
    enable_tlblookup_o = 1'b1;
    enable_wb_o        = 1'b1;
    bubble_alu_o       = 1'b0;
    bubble_wb_o        = 1'b0;
    flush_decode_o     = 1'b0;

    if (!reset_i) begin
      unique case (state_q)
        StRun: begin
          if (tlb_miss_i) begin
            // Freeze everything but wb, which drains a bubble.
            enable_pc_o        = 1'b0;
            enable_decode_o    = 1'b0;
            enable_alu_o       = 1'b0;
            enable_tlblookup_o = 1'b0;
            bubble_wb_o        = 1'b1;
            wb_v_d             = 1'b0;
            miss_inc           = 1'b1;
            state_d            = StMissWait;
          end else if (raw) begin
            enable_pc_o     = 1'b0;
            enable_decode_o = 1'b0;
            bubble_alu_o    = 1'b1;
            alu_v_d         = 1'b0;
            tlb_v_d         = alu_v_q;
            tlb_a_d         = alu_a_q;
            wb_v_d          = tlb_v_q;
            wb_a_d          = tlb_a_q;
          end else begin
            alu_v_d        = dv & dec_we_i;
            alu_a_d        = dec_dest_addr_i;
            tlb_v_d        = alu_v_q;
            tlb_a_d        = alu_a_q;
            wb_v_d         = tlb_v_q;
            wb_a_d         = tlb_a_q;
            flush_decode_o = dv & dec_branch_taken_i;
            kill_d         = dv & dec_branch_taken_i;
          end
        end
        StMissWait: begin
          enable_pc_o        = 1'b0;
          enable_decode_o    = 1'b0;
          enable_alu_o       = 1'b0;
          enable_tlblookup_o = 1'b0;
          bubble_wb_o        = 1'b1;
          wb_v_d             = 1'b0;
          if (tlb_miss_done_i) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StRun;
      kill_q  <= 1'b0;
      alu_v_q <= 1'b0;
      alu_a_q <= '0;
      tlb_v_q <= 1'b0;
      tlb_a_q <= '0;
      wb_v_q  <= 1'b0;
      wb_a_q  <= '0;
      stall_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      alu_v_q <= alu_v_d;
      alu_a_q <= alu_a_d;
      tlb_v_q <= tlb_v_d;
      tlb_a_q <= tlb_a_d;
      wb_v_q  <= wb_v_d;
      wb_a_q  <= wb_a_d;
      if (!enable_pc_o && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (miss_inc && (miss_q != '1)) begin
        miss_q <= miss_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles_o = stall_q;
  assign miss_count_o   = miss_q;

endmodule
